// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path and the drawing blocks.
package wave_pkg;

    localparam int DEPTH      = 1280;
    localparam int AW         = 11;
    localparam int DW         = 10;
    localparam int TRIG_LEVEL = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } wave_state_e;

endpackage

// File: rtl/wave_trigger_detect.sv
// Level-crossing trigger with auto-trigger timeout; evaluates one sample per strobe.
module wave_trigger_detect #(
    parameter int DW         = 10,
    parameter int TRIG_LEVEL = 512,
    parameter int TIMEOUT    = 4000
) (
    input  logic          CLK_VGA,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic          strobe,
    input  logic [DW-1:0] sample,
    input  logic          slope,
    output logic          trig_hit,
    output logic          is_auto
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] LEVEL    = DW'(TRIG_LEVEL);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    logic [DW-1:0] prev_sample_q, prev_sample_d;
    logic          prev_valid_q, prev_valid_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          crossed;
    logic          timed_out;

    always_comb begin
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        to_cnt_d      = to_cnt_q;
        trig_hit      = 1'b0;
        is_auto       = 1'b0;
        crossed       = slope ? (prev_sample_q >= LEVEL && sample < LEVEL)
                              : (prev_sample_q < LEVEL && sample >= LEVEL);
        timed_out     = (to_cnt_q == TO_LAST);
        if (clear) begin
            prev_valid_d = 1'b0;
            to_cnt_d     = '0;
        end else if (enable && strobe) begin
            prev_sample_d = sample;
            prev_valid_d  = 1'b1;
            // The loading strobe has no reference sample, so it neither triggers nor counts.
            if (prev_valid_q) begin
                trig_hit = crossed || timed_out;
                is_auto  = !crossed && timed_out;
                to_cnt_d = trig_hit ? '0 : to_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK_VGA or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Triggered single-frame capture into the waveform sample RAM, with frame-count hold and freeze.
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter int DEPTH       = wave_pkg::DEPTH,
    parameter int AW          = wave_pkg::AW,
    parameter int DW          = wave_pkg::DW,
    parameter int TRIG_LEVEL  = wave_pkg::TRIG_LEVEL,
    parameter int TIMEOUT     = 4000,
    parameter int HOLD_FRAMES = 2
) (
    input  logic          CLK_VGA,
    input  logic          rst_n,
    input  logic          sample_strobe,
    input  logic [DW-1:0] wave_sample,
    input  logic          trig_slope,
    input  logic          freeze,
    input  logic          rearm,
    input  logic          frame_start,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          capturing,
    output logic          triggered,
    output logic          auto_trig,
    output logic [1:0]    state_o
);

    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [FW-1:0] HOLD_CNT  = FW'(HOLD_FRAMES);

    wave_state_e   state_q, state_d;
    logic [AW-1:0] addr_cnt_q, addr_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          triggered_q, triggered_d;
    logic          auto_trig_q, auto_trig_d;
    logic          trig_hit;
    logic          is_auto;

    // The detector only observes samples while armed; anywhere else its history is flushed.
    wave_trigger_detect #(
        .DW         (DW),
        .TRIG_LEVEL (TRIG_LEVEL),
        .TIMEOUT    (TIMEOUT)
    ) u_trig (
        .CLK_VGA  (CLK_VGA),
        .rst_n    (rst_n),
        .clear    (rearm || state_q != ST_ARMED),
        .enable   (state_q == ST_ARMED),
        .strobe   (sample_strobe),
        .sample   (wave_sample),
        .slope    (trig_slope),
        .trig_hit (trig_hit),
        .is_auto  (is_auto)
    );

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        frame_cnt_d = frame_cnt_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        triggered_d = triggered_q;
        auto_trig_d = auto_trig_q;
        if (rearm) begin
            state_d     = ST_ARMED;
            addr_cnt_d  = '0;
            frame_cnt_d = '0;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trig_hit) begin
                        state_d     = ST_CAPTURE;
                        triggered_d = 1'b1;
                        auto_trig_d = is_auto;
                        mem_we_d    = 1'b1;
                        mem_waddr_d = '0;
                        mem_wdata_d = wave_sample;
                        addr_cnt_d  = AW'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (sample_strobe) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = addr_cnt_q;
                        mem_wdata_d = wave_sample;
                        if (addr_cnt_q == LAST_ADDR) begin
                            state_d     = ST_HOLD;
                            addr_cnt_d  = '0;
                            frame_cnt_d = '0;
                        end else begin
                            addr_cnt_d = addr_cnt_q + AW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Saturate so a long freeze still re-arms right after release.
                    if (frame_start && frame_cnt_q != HOLD_CNT) begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                    if (frame_cnt_q == HOLD_CNT && !freeze) begin
                        state_d     = ST_ARMED;
                        triggered_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_VGA or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_cnt_q  <= '0;
            frame_cnt_q <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            triggered_q <= 1'b0;
            auto_trig_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            triggered_q <= triggered_d;
            auto_trig_q <= auto_trig_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign capturing = (state_q == ST_CAPTURE);
    assign triggered = triggered_q;
    assign auto_trig = auto_trig_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl (TIMEOUT=4, HOLD_FRAMES=2).
module tb_wave_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_strobe;
    logic [9:0]  wave_sample;
    logic        trig_slope;
    logic        freeze;
    logic        rearm;
    logic        frame_start;
    logic        mem_we;
    logic [10:0] mem_waddr;
    logic [9:0]  mem_wdata;
    logic        capturing;
    logic        triggered;
    logic        auto_trig;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int base;

    always #5 clk = ~clk;

    wave_capture_ctrl #(
        .DEPTH(1280), .AW(11), .DW(10), .TRIG_LEVEL(512), .TIMEOUT(4), .HOLD_FRAMES(2)
    ) dut (
        .CLK_VGA(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .wave_sample(wave_sample),
        .trig_slope(trig_slope), .freeze(freeze), .rearm(rearm), .frame_start(frame_start),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .capturing(capturing),
        .triggered(triggered), .auto_trig(auto_trig), .state_o(state_o)
    );

    // Each write pulse spans exactly one cycle, so mid-cycle sampling counts it once.
    always @(negedge clk) if (mem_we === 1'b1) we_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] v);
        wave_sample   = v;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_strobe = 1'b0; wave_sample = '0; trig_slope = 1'b0;
        freeze = 1'b0; rearm = 1'b0; frame_start = 1'b0;
        tick(); tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", mem_we); end
        checks++; if (mem_waddr !== 11'd0 || mem_wdata !== 10'd0) begin errors++; $display("FAIL reset_addr_data: got %0d/%0d expected 0/0", mem_waddr, mem_wdata); end
        checks++; if (triggered !== 1'b0 || auto_trig !== 1'b0 || capturing !== 1'b0) begin errors++; $display("FAIL reset_flags: got trig=%0b auto=%0b cap=%0b expected 0/0/0", triggered, auto_trig, capturing); end
        rst_n = 1'b1;
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL idle_to_armed: got %0d expected 1", state_o); end
        $display("test_reset done");
    endtask

    task automatic test_rising_trigger();
        strobe(10'd100);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rise_first_load: got we=%0b expected 0", mem_we); end
        strobe(10'd300);
        checks++; if (mem_we !== 1'b0 || state_o !== 2'd1) begin errors++; $display("FAIL rise_below: got we=%0b state=%0d expected 0/1", mem_we, state_o); end
        base = we_count;
        strobe(10'd600);
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 11'd0 || mem_wdata !== 10'd600) begin errors++; $display("FAIL rise_write: got we=%0b addr=%0d data=%0d expected 1/0/600", mem_we, mem_waddr, mem_wdata); end
        checks++; if (triggered !== 1'b1 || auto_trig !== 1'b0 || capturing !== 1'b1) begin errors++; $display("FAIL rise_flags: got trig=%0b auto=%0b cap=%0b expected 1/0/1", triggered, auto_trig, capturing); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rise_we_pulse: got %0b expected 0", mem_we); end
        $display("test_rising_trigger: trigger on 600 written at addr %0d", mem_waddr);
    endtask

    task automatic finish_capture(input int first_addr, input string tag);
        int bad = 0;
        for (int a = first_addr; a < 1280; a++) begin
            logic [9:0] v;
            v = 10'(a - 1);
            strobe(v);
            checks++;
            if (mem_we !== 1'b1 || mem_waddr !== 11'(a) || mem_wdata !== v) begin
                errors++; bad++;
                if (bad <= 5) $display("FAIL %s_write: got we=%0b addr=%0d data=%0d expected 1/%0d/%0d", tag, mem_we, mem_waddr, mem_wdata, a, v);
            end
        end
    endtask

    task automatic test_full_capture();
        finish_capture(1, "cap");
        checks++; if (mem_waddr !== 11'd1279) begin errors++; $display("FAIL cap_last_addr: got %0d expected 1279", mem_waddr); end
        checks++; if (state_o !== 2'd3 || capturing !== 1'b0) begin errors++; $display("FAIL cap_to_hold: got state=%0d cap=%0b expected 3/0", state_o, capturing); end
        tick();
        checks++; if (we_count - base !== 1280) begin errors++; $display("FAIL cap_count: got %0d expected 1280", we_count - base); end
        strobe(10'd700);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL hold_no_write: got we=%0b expected 0", mem_we); end
        $display("test_full_capture: %0d writes", we_count - base);
    endtask

    task automatic test_freeze_hold();
        freeze = 1'b1;
        for (int p = 0; p < 5; p++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
            checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL freeze_hold_%0d: got state=%0d expected 3", p, state_o); end
        end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL freeze_triggered: got %0b expected 1", triggered); end
        freeze = 1'b0;
        tick();
        checks++; if (state_o !== 2'd1 || triggered !== 1'b0) begin errors++; $display("FAIL freeze_release: got state=%0d trig=%0b expected 1/0", state_o, triggered); end
        $display("test_freeze_hold: re-armed after freeze release");
    endtask

    task automatic test_timeout();
        for (int s = 0; s < 4; s++) begin
            strobe(10'd200);
            checks++; if (mem_we !== 1'b0 || state_o !== 2'd1) begin errors++; $display("FAIL to_wait_%0d: got we=%0b state=%0d expected 0/1", s, mem_we, state_o); end
        end
        strobe(10'd200);
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 11'd0 || mem_wdata !== 10'd200) begin errors++; $display("FAIL to_write: got we=%0b addr=%0d data=%0d expected 1/0/200", mem_we, mem_waddr, mem_wdata); end
        checks++; if (auto_trig !== 1'b1 || triggered !== 1'b1) begin errors++; $display("FAIL to_flags: got auto=%0b trig=%0b expected 1/1", auto_trig, triggered); end
        $display("test_timeout: auto-trigger on 5th strobe");
    endtask

    task automatic test_rearm();
        for (int a = 1; a < 700; a++) strobe(10'(a));
        checks++; if (mem_waddr !== 11'd699) begin errors++; $display("FAIL rearm_pre_addr: got %0d expected 699", mem_waddr); end
        rearm = 1'b1; wave_sample = 10'd900; sample_strobe = 1'b1;
        tick();
        rearm = 1'b0; sample_strobe = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rearm_drop: got we=%0b expected 0", mem_we); end
        checks++; if (state_o !== 2'd1 || triggered !== 1'b0) begin errors++; $display("FAIL rearm_state: got state=%0d trig=%0b expected 1/0", state_o, triggered); end
        strobe(10'd600);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rearm_fresh_load: got we=%0b expected 0", mem_we); end
        strobe(10'd100);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rearm_wrong_slope: got we=%0b expected 0", mem_we); end
        strobe(10'd900);
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 11'd0 || mem_wdata !== 10'd900 || auto_trig !== 1'b0) begin errors++; $display("FAIL rearm_restart: got we=%0b addr=%0d data=%0d auto=%0b expected 1/0/900/0", mem_we, mem_waddr, mem_wdata, auto_trig); end
        finish_capture(1, "recap");
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL hold_one_frame: got state=%0d expected 3", state_o); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL hold_two_frames: got state=%0d expected 3", state_o); end
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL hold_rearm: got state=%0d expected 1", state_o); end
        $display("test_rearm: restart at addr 0, hold released after 2 frames");
    endtask

    task automatic test_falling_and_async_reset();
        trig_slope = 1'b1;
        strobe(10'd800);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fall_load: got we=%0b expected 0", mem_we); end
        strobe(10'd400);
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 11'd0 || mem_wdata !== 10'd400 || state_o !== 2'd2) begin errors++; $display("FAIL fall_write: got we=%0b addr=%0d data=%0d state=%0d expected 1/0/400/2", mem_we, mem_waddr, mem_wdata, state_o); end
        strobe(10'd5);
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 11'd1) begin errors++; $display("FAIL fall_second: got we=%0b addr=%0d expected 1/1", mem_we, mem_waddr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL async_reset: got we=%0b state=%0d expected 0/0", mem_we, state_o); end
        checks++; if (triggered !== 1'b0 || capturing !== 1'b0 || mem_waddr !== 11'd0) begin errors++; $display("FAIL async_reset_flags: got trig=%0b cap=%0b addr=%0d expected 0/0/0", triggered, capturing, mem_waddr); end
        $display("test_falling_and_async_reset done");
    endtask

    initial begin
        test_reset();
        test_rising_trigger();
        test_full_capture();
        test_freeze_hold();
        test_timeout();
        test_rearm();
        test_falling_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
Triggered-capture controller for the 1280-point waveform sample memory. It watches the 20 kHz sample stream and detects a level-crossing trigger, with an auto-trigger timeout. It then sequences exactly one frame of writes (addresses 0..1279) into the sample RAM and holds the captured frame for a set number of VGA frames before re-arming. It runs in the CLK_VGA domain, sits between the audio sampler and the waveform drawing logic, and replaces free-running circular writes with stable, trigger-aligned captures.

Parameters:
DEPTH, 1280, number of sample points per captured frame
AW, 11, sample memory address width
DW, 10, sample width
TRIG_LEVEL, 512, trigger threshold (mid-scale)
TIMEOUT, 4000, strobes in ARMED without a trigger before auto-trigger
HOLD_FRAMES, 2, frame_start pulses to hold a completed capture before re-arming

Ports:
CLK_VGA  in  1  system clock; the only clock
rst_n  in  1  asynchronous active-low reset
sample_strobe  in  1  one-cycle pulse per new sample, already synchronised to CLK_VGA
wave_sample  in  DW  sample value, valid when sample_strobe=1
trig_slope  in  1  0 = rising crossing, 1 = falling crossing
freeze  in  1  level; holds the current frame indefinitely once in HOLD
rearm  in  1  one-cycle pulse; abort and return to ARMED
frame_start  in  1  one-cycle pulse at VGA frame start
mem_we  out  1  sample RAM write enable
mem_waddr  out  AW  sample RAM write address
mem_wdata  out  DW  sample RAM write data
capturing  out  1  high in CAPTURE
triggered  out  1  high from the trigger until the return to ARMED
auto_trig  out  1  high if the last trigger came from the timeout
state_o  out  2  encoded state for debug/LED

Behaviour:
- Reset (async assert, sync release): state IDLE. mem_we, mem_waddr, mem_wdata, capturing, triggered, auto_trig, the internal counters, prev_sample and prev_valid are all 0.
- States: IDLE=0, ARMED=1, CAPTURE=2, HOLD=3. IDLE -> ARMED unconditionally on the next clock.
- ARMED, per strobe:
  - If prev_valid=0: load prev_sample, set prev_valid. The first strobe never triggers.
  - Otherwise the trigger condition is prev<TRIG_LEVEL && cur>=TRIG_LEVEL (rising), or prev>=TRIG_LEVEL && cur<TRIG_LEVEL (falling).
  - A timeout counter increments per non-triggering strobe.
  - On trigger, or when the counter reaches TIMEOUT-1 on a strobe: go to CAPTURE. Set triggered=1; set auto_trig=1 for a timeout, else 0. The triggering strobe's sample is written at address 0.
- Write timing: every accepted strobe in CAPTURE, plus the trigger strobe, produces a registered write. On the cycle after the strobe: mem_we=1 for exactly one cycle, with mem_waddr and mem_wdata valid. Latency is 1 cycle.
- CAPTURE:
  - Address increments per strobe, with no wrap.
  - After the write at DEPTH-1: go to HOLD and reset the frame counter. Exactly DEPTH writes occur per capture.
- HOLD:
  - No writes.
  - frame_start increments the frame counter.
  - When the counter reaches HOLD_FRAMES and freeze=0: go to ARMED, clear prev_valid, the timeout counter and triggered.
  - If freeze=1, stay in HOLD. Pulses still count, saturating at HOLD_FRAMES, so releasing freeze re-arms on the next cycle.
- freeze asserted in ARMED or CAPTURE has no effect until HOLD; a capture in progress always completes.
- rearm: from any state, the next state is ARMED with counters, prev_valid and triggered cleared and mem_we=0. A strobe coinciding with rearm is dropped, with no write. rearm has priority over trigger, strobe and frame_start.
- A strobe and frame_start in the same cycle are processed independently.
- Arithmetic: comparisons are unsigned DW-bit. The address counter is AW bits and must never exceed DEPTH-1.
- Reset mid-CAPTURE: outputs clear immediately (async), and the partial frame is abandoned.

Decomposition:
- Shared package wave_pkg: the state encoding constants, DEPTH/AW/DW defaults, and TRIG_LEVEL. The drawing blocks use the same DEPTH/DW.
- One natural sub-module, wave_trigger_detect: holds prev_sample/prev_valid, applies the slope compare, and runs the timeout counter. It outputs a one-cycle trig_hit and an is_auto flag.

Test Plan:
1. Reset, then strobes 100,300,600 with trig_slope=0 → no trigger on 100 (first strobe only loads prev); trigger on 600; mem_we the next cycle with waddr=0, wdata=600; triggered=1, auto_trig=0.
2. After the trigger, 1279 more strobes with values 0..1278 mod 1024 → exactly 1280 total writes, last waddr=1279; state goes to HOLD; further strobes produce no mem_we.
3. Constant sample 200 with TIMEOUT=4 → auto-trigger on the 5th strobe (1 load + 4 counted); auto_trig=1; first write has waddr=0, wdata=200.
4. In HOLD with HOLD_FRAMES=2, freeze=1, 5 frame_start pulses → stays in HOLD; freeze drops → ARMED the next cycle with triggered=0.
5. rearm at capture address 700, coinciding with a strobe → no write that cycle; state ARMED; next capture restarts at waddr=0 after a fresh prev load.
6. trig_slope=1, strobes 800,400 → trigger on 400; write waddr=0, wdata=400. Assert rst_n=0 mid-CAPTURE → mem_we=0 and state_o=0 without waiting for a clock edge.
